// File: rtl/dadda_product_accumulator_16_if.sv
// Product-stream / frame-result bus for dadda_product_accumulator_16.
//
// Handshake rules (both channels): a transfer happens on a rising clk edge
// where valid && ready are both 1. A producer holding valid keeps its data
// stable until that transfer. The input channel's ready is combinational
// from state and clear. The output channel's valid is registered.
//
// Signals
//   clear         master->slave  abort the current frame and any pending result
//   len           master->slave  products per frame (0 counts as 1)
//   in_valid      master->slave  in_product is valid
//   in_ready      slave->master  accumulator takes in_product this cycle
//   in_product    master->slave  unsigned product
//   out_valid     slave->master  frame result is valid
//   out_ready     master->slave  downstream takes the result
//   out_acc       slave->master  saturated frame sum
//   out_count     slave->master  products summed in the frame
//   out_overflow  slave->master  frame sum saturated
interface dadda_product_accumulator_16_if #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
);
  logic              clear;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic [LEN_W-1:0]  out_count;
  logic              out_overflow;

  modport master (
    output clear, len, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_acc, out_count, out_overflow
  );

  modport slave (
    input  clear, len, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_acc, out_count, out_overflow
  );
endinterface

// File: rtl/dadda_product_accumulator_16.sv
// Multiply-accumulate back end for the 16x16 Dadda multiplier. Sums a frame
// of len unsigned products, saturating at ACC_W bits, and hands one result
// per frame downstream over a valid/ready handshake.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   bus          slave side of dadda_product_accumulator_16_if
//   o_dbg_state  current FSM state (0 = ACCUM, 1 = HOLD)
module dadda_product_accumulator_16 #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int LEN_W  = 8
) (
  input  logic clk,
  input  logic rst,
  dadda_product_accumulator_16_if.slave bus,
  output logic o_dbg_state
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [ACC_W-1:0]   r_acc, w_acc_nxt;
  logic [LEN_W-1:0]   r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]   r_len_q, w_len_q_nxt;
  logic               r_ovf_q, w_ovf_q_nxt;
  logic               r_out_valid, w_out_valid_nxt;
  logic [ACC_W-1:0]   r_out_acc, w_out_acc_nxt;
  logic [LEN_W-1:0]   r_out_count, w_out_count_nxt;
  logic               r_out_ovf, w_out_ovf_nxt;

  logic               w_in_ready;
  logic               w_accept;
  logic [LEN_W-1:0]   w_len_eff;
  logic [ACC_W:0]     w_sum;
  logic               w_ovf;
  logic [ACC_W-1:0]   w_sum_sat;
  logic               w_last;

  assign w_in_ready = (r_state == ST_ACCUM) && !bus.clear && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;

  // len is only looked at on the first beat; later beats use the latched copy.
  assign w_len_eff = (r_cnt != '0) ? r_len_q :
                     ((bus.len == '0) ? LEN_W'(1) : bus.len);

  // One extra bit catches the carry that signals saturation.
  assign w_sum     = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_product};
  assign w_ovf     = w_sum[ACC_W] || r_ovf_q;
  assign w_sum_sat = w_ovf ? '1 : w_sum[ACC_W-1:0];
  assign w_last    = ((r_cnt + LEN_W'(1)) == w_len_eff);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_len_q_nxt     = r_len_q;
    w_ovf_q_nxt     = r_ovf_q;
    w_out_valid_nxt = r_out_valid;
    w_out_acc_nxt   = r_out_acc;
    w_out_count_nxt = r_out_count;
    w_out_ovf_nxt   = r_out_ovf;

    if (bus.clear) begin
      // Result data registers keep their last values; only valid drops.
      w_state_nxt     = ST_ACCUM;
      w_acc_nxt       = '0;
      w_cnt_nxt       = '0;
      w_ovf_q_nxt     = 1'b0;
      w_out_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_accept) begin
            w_len_q_nxt = w_len_eff;
            if (w_last) begin
              w_out_acc_nxt   = w_sum_sat;
              w_out_count_nxt = w_len_eff;
              w_out_ovf_nxt   = w_ovf;
              w_out_valid_nxt = 1'b1;
              w_acc_nxt       = '0;
              w_cnt_nxt       = '0;
              w_ovf_q_nxt     = 1'b0;
              w_state_nxt     = ST_HOLD;
            end else begin
              w_acc_nxt   = w_sum_sat;
              w_cnt_nxt   = r_cnt + LEN_W'(1);
              w_ovf_q_nxt = w_ovf;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            w_out_valid_nxt = 1'b0;
            w_state_nxt     = ST_ACCUM;
          end
        end
        default: w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_len_q     <= '0;
      r_ovf_q     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_acc   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len_q     <= w_len_q_nxt;
      r_ovf_q     <= w_ovf_q_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_acc   <= w_out_acc_nxt;
      r_out_count <= w_out_count_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign bus.in_ready     = w_in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_acc      = r_out_acc;
  assign bus.out_count    = r_out_count;
  assign bus.out_overflow = r_out_ovf;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_dadda_product_accumulator_16.sv
module tb_dadda_product_accumulator_16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;
  logic dbg_state33;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic [39:0] exp_q[$];
  logic [39:0] exp_v;

  dadda_product_accumulator_16_if #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) bus ();
  dadda_product_accumulator_16_if #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) bus33 ();

  dadda_product_accumulator_16 #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .o_dbg_state(dbg_state)
  );

  dadda_product_accumulator_16 #(.PROD_W(32), .ACC_W(33), .LEN_W(8)) dut33 (
    .clk(clk), .rst(rst), .bus(bus33.slave), .o_dbg_state(dbg_state33)
  );

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 20000) begin
      $display("FAIL watchdog: cycles %0d exceeded limit 20000", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] p);
    bus.in_valid   = 1'b1;
    bus.in_product = p;
    tick();
    bus.in_valid   = 1'b0;
  endtask

  task automatic beat33(input logic [31:0] p);
    bus33.in_valid   = 1'b1;
    bus33.in_product = p;
    tick();
    bus33.in_valid   = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_product = 32'd123;
    tick();
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0d want 0", bus.out_valid); end
    n_vec++; if (bus.out_acc !== 40'd0) begin n_err++; $display("FAIL rst_out_acc got %0d want 0", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd0) begin n_err++; $display("FAIL rst_out_count got %0d want 0", bus.out_count); end
    n_vec++; if (bus.out_overflow !== 1'b0) begin n_err++; $display("FAIL rst_out_overflow got %0d want 0", bus.out_overflow); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready got %0d want 0", bus.in_ready); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL rst_state got %0d want 0", dbg_state); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready got %0d want 1", bus.in_ready); end
    tick();
  endtask

  task automatic test_frame3();
    bus.out_ready = 1'b1;
    bus.len = 8'd3;
    bus.in_valid = 1'b1;
    bus.in_product = 32'd100; tick();
    bus.in_product = 32'd200; tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL f3_early_valid got %0d want 0", bus.out_valid); end
    bus.in_product = 32'd300; tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL f3_valid got %0d want 1", bus.out_valid); end
    n_vec++; if (bus.out_acc !== 40'd600) begin n_err++; $display("FAIL f3_acc got %0d want 600", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd3) begin n_err++; $display("FAIL f3_count got %0d want 3", bus.out_count); end
    n_vec++; if (bus.out_overflow !== 1'b0) begin n_err++; $display("FAIL f3_ovf got %0d want 0", bus.out_overflow); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL f3_pulse_end got %0d want 0", bus.out_valid); end
  endtask

  task automatic test_single_hold();
    bus.out_ready = 1'b0;
    bus.len = 8'd1;
    beat(32'd39812471);   // 10097 * 3943
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %0d want 1", bus.out_valid); end
    n_vec++; if (bus.out_acc !== 40'd39812471) begin n_err++; $display("FAIL single_acc got %0d want 39812471", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd1) begin n_err++; $display("FAIL single_count got %0d want 1", bus.out_count); end
    bus.in_valid = 1'b1;
    bus.in_product = 32'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL single_hold_ready[%0d] got %0d want 0", i, bus.in_ready); end
      tick();
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_hold_valid[%0d] got %0d want 1", i, bus.out_valid); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_release got %0d want 0", bus.out_valid); end
  endtask

  task automatic test_saturate();
    bus33.out_ready = 1'b1;
    bus33.len = 8'd3;
    bus33.in_valid = 1'b1;
    bus33.in_product = 32'hFFFE0001;
    tick(); tick(); tick();
    bus33.in_valid = 1'b0;
    n_vec++; if (bus33.out_valid !== 1'b1) begin n_err++; $display("FAIL sat_valid got %0d want 1", bus33.out_valid); end
    n_vec++; if (bus33.out_acc !== 33'h1FFFFFFFF) begin n_err++; $display("FAIL sat_acc got %0h want 1ffffffff", bus33.out_acc); end
    n_vec++; if (bus33.out_overflow !== 1'b1) begin n_err++; $display("FAIL sat_ovf got %0d want 1", bus33.out_overflow); end
    n_vec++; if (bus33.out_count !== 8'd3) begin n_err++; $display("FAIL sat_count got %0d want 3", bus33.out_count); end
    tick();
    bus33.len = 8'd2;
    beat33(32'd5);
    beat33(32'd6);
    n_vec++; if (bus33.out_valid !== 1'b1) begin n_err++; $display("FAIL sat_next_valid got %0d want 1", bus33.out_valid); end
    n_vec++; if (bus33.out_acc !== 33'd11) begin n_err++; $display("FAIL sat_next_acc got %0d want 11", bus33.out_acc); end
    n_vec++; if (bus33.out_overflow !== 1'b0) begin n_err++; $display("FAIL sat_next_ovf got %0d want 0", bus33.out_overflow); end
    tick();
  endtask

  task automatic test_clear();
    bus.out_ready = 1'b1;
    bus.len = 8'd4;
    beat(32'd1000);
    beat(32'd2000);
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_product = 32'd999;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL clr_in_ready got %0d want 0", bus.in_ready); end
    tick();
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL clr_out_valid got %0d want 0", bus.out_valid); end
    // Clear while a result waits in HOLD: valid drops, data is kept.
    bus.out_ready = 1'b0;
    bus.len = 8'd1;
    beat(32'd77);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL clr_hold_valid got %0d want 1", bus.out_valid); end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL clr_hold_drop got %0d want 0", bus.out_valid); end
    n_vec++; if (bus.out_acc !== 40'd77) begin n_err++; $display("FAIL clr_hold_acc got %0d want 77", bus.out_acc); end
    n_vec++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL clr_hold_state got %0d want 0", dbg_state); end
    bus.out_ready = 1'b1;
    bus.len = 8'd4;
    beat(32'd1); beat(32'd2); beat(32'd3); beat(32'd4);
    n_vec++; if (bus.out_acc !== 40'd10) begin n_err++; $display("FAIL clr_next_acc got %0d want 10", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd4) begin n_err++; $display("FAIL clr_next_count got %0d want 4", bus.out_count); end
    tick();
  endtask

  task automatic test_hold_stall();
    bus.out_ready = 1'b0;
    bus.len = 8'd2;
    beat(32'd7);
    beat(32'd8);
    bus.in_valid = 1'b1;
    bus.in_product = 32'd50;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d] got %0d want 0", i, bus.in_ready); end
      n_vec++; if (bus.out_acc !== 40'd15) begin n_err++; $display("FAIL stall_acc[%0d] got %0d want 15", i, bus.out_acc); end
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %0d want 1", i, bus.out_valid); end
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_hs_ready got %0d want 0", bus.in_ready); end
    tick();   // result handshake; beat still held off this edge
    bus.len = 8'd1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL stall_after_ready got %0d want 1", bus.in_ready); end
    tick();   // beat 50 accepted
    bus.in_valid = 1'b0;
    n_vec++; if (bus.out_acc !== 40'd50) begin n_err++; $display("FAIL stall_next_acc got %0d want 50", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd1) begin n_err++; $display("FAIL stall_next_count got %0d want 1", bus.out_count); end
    tick();
  endtask

  task automatic test_len_change();
    bus.out_ready = 1'b1;
    bus.len = 8'd2;
    beat(32'd1);
    bus.len = 8'd5;
    beat(32'd2);
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL lenchg_valid got %0d want 1", bus.out_valid); end
    n_vec++; if (bus.out_count !== 8'd2) begin n_err++; $display("FAIL lenchg_count got %0d want 2", bus.out_count); end
    n_vec++; if (bus.out_acc !== 40'd3) begin n_err++; $display("FAIL lenchg_acc got %0d want 3", bus.out_acc); end
    tick();
  endtask

  task automatic test_back_to_back();
    // Frames of len 2, each result consumed on the edge after it appears.
    bus.out_ready = 1'b1;
    bus.len = 8'd2;
    exp_q.push_back(40'd300);
    exp_q.push_back(40'd4294967295 + 40'd1);
    exp_q.push_back(40'd9);
    beat(32'd100); beat(32'd200); tick();
    exp_v = exp_q.pop_front();
    n_vec++; if (bus.out_acc !== exp_v) begin n_err++; $display("FAIL b2b0_acc got %0d want %0d", bus.out_acc, exp_v); end
    beat(32'hFFFFFFFF); beat(32'd1); tick();
    exp_v = exp_q.pop_front();
    n_vec++; if (bus.out_acc !== exp_v) begin n_err++; $display("FAIL b2b1_acc got %0d want %0d", bus.out_acc, exp_v); end
    beat(32'd4); beat(32'd5); tick();
    exp_v = exp_q.pop_front();
    n_vec++; if (bus.out_acc !== exp_v) begin n_err++; $display("FAIL b2b2_acc got %0d want %0d", bus.out_acc, exp_v); end
  endtask

  task automatic test_len0_reset();
    bus.out_ready = 1'b1;
    bus.len = 8'd0;
    beat(32'd7);
    n_vec++; if (bus.out_acc !== 40'd7) begin n_err++; $display("FAIL len0_acc got %0d want 7", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd1) begin n_err++; $display("FAIL len0_count got %0d want 1", bus.out_count); end
    tick();
    bus.len = 8'd3;
    beat(32'd10);
    beat(32'd20);
    rst = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %0d want 0", bus.in_ready); end
    tick();
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got %0d want 0", bus.out_valid); end
    n_vec++; if (bus.out_acc !== 40'd0) begin n_err++; $display("FAIL midrst_acc got %0d want 0", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd0) begin n_err++; $display("FAIL midrst_count got %0d want 0", bus.out_count); end
    rst = 1'b0;
    bus.len = 8'd1;
    beat(32'd5);
    n_vec++; if (bus.out_acc !== 40'd5) begin n_err++; $display("FAIL postrst_acc got %0d want 5", bus.out_acc); end
    n_vec++; if (bus.out_count !== 8'd1) begin n_err++; $display("FAIL postrst_count got %0d want 1", bus.out_count); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.clear = 1'b0;     bus.len = 8'd0;   bus.in_valid = 1'b0;
    bus.in_product = '0;  bus.out_ready = 1'b1;
    bus33.clear = 1'b0;   bus33.len = 8'd0; bus33.in_valid = 1'b0;
    bus33.in_product = '0; bus33.out_ready = 1'b1;
    #1;
    test_reset();
    test_frame3();
    test_single_hold();
    test_saturate();
    test_clear();
    test_hold_stall();
    test_len_change();
    test_back_to_back();
    test_len0_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
